step_motion_scheduler: RTL

Central motion controller for the stepper datapath. It arbitrates between continuous-run requests (SW2) and counted quarter-turn requests (KEY1). It generates the step_pulse timebase and advances the coil phase sequencer, which drives the motor driver outputs directly. It sits between the board switches and keys and the motor driver pins, and replaces ad-hoc step counting in individual mode blocks.

---
 rtl/step_motion_scheduler_pkg.sv | 22 ++
 rtl/step_motion_scheduler_rate_gen.sv | 63 ++++++
 rtl/step_motion_scheduler.sv | 128 ++++++++++++
 3 files changed

// File: rtl/step_motion_scheduler_pkg.sv
// Shared types and constants for the stepper motion scheduler and its rate generator.
package step_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONT    = 2'd1,
    QUARTER = 2'd2
  } motion_state_t;

  localparam logic [6:0] QUARTER_STEPS_FULL = 7'd50;
  localparam logic [6:0] QUARTER_STEPS_HALF = 7'd100;

  localparam logic [3:0] COIL_TABLE [8] = '{
    4'b0001, 4'b0011, 4'b0010, 4'b0110,
    4'b0100, 4'b1100, 4'b1000, 4'b1001
  };

  function automatic logic [3:0] coil_pattern(input logic [2:0] idx);
    return COIL_TABLE[idx];
  endfunction

endpackage

// File: rtl/step_motion_scheduler_rate_gen.sv
// Step timebase: one-cycle registered strobe every 'period' cycles while run is high.
// STEP_RAMP_EN adds a soft start (period << ramp_sh, ramp_sh 3..0 stepping down every 4 strobes).
module step_rate_gen #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  output logic                step_pulse
);

`ifdef STEP_RAMP_EN
  localparam int CNT_W = PERIOD_W + 3;
  logic [1:0]       r_ramp_sh;
  logic [1:0]       r_ramp_cnt;
  logic [CNT_W-1:0] w_last;

  assign w_last = ({3'b000, period} << r_ramp_sh) - CNT_W'(1);

  // ramp re-arms whenever the generator is idle, so every entry starts slow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ramp_sh  <= 2'd3;
      r_ramp_cnt <= 2'd0;
    end else if (!run) begin
      r_ramp_sh  <= 2'd3;
      r_ramp_cnt <= 2'd0;
    end else if (r_pulse) begin
      r_ramp_cnt <= r_ramp_cnt + 2'd1;
      if (r_ramp_cnt == 2'd3 && r_ramp_sh != 2'd0)
        r_ramp_sh <= r_ramp_sh - 2'd1;
    end
  end
`else
  localparam int CNT_W = PERIOD_W;
  logic [CNT_W-1:0] w_last;

  assign w_last = period - CNT_W'(1);
`endif

  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (!run) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (r_cnt == w_last) begin
      r_cnt   <= '0;
      r_pulse <= 1'b1;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
      r_pulse <= 1'b0;
    end
  end

  assign step_pulse = r_pulse;

endmodule

// File: rtl/step_motion_scheduler.sv
// Motion scheduler: arbitrates continuous run vs counted quarter turns and drives the coil sequencer.
// Optional soft start lives in step_rate_gen under STEP_RAMP_EN.
module step_motion_scheduler
  import step_pkg::*;
#(
  parameter int                  PERIOD_W = 24,
  parameter logic [PERIOD_W-1:0] PERIOD0  = 24'd500000,
  parameter logic [PERIOD_W-1:0] PERIOD1  = 24'd250000,
  parameter logic [PERIOD_W-1:0] PERIOD2  = 24'd125000,
  parameter logic [PERIOD_W-1:0] PERIOD3  = 24'd62500
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cont_en,
  input  logic       quarter_n,
  input  logic       dir,
  input  logic       step_size,
  input  logic [1:0] speed_sel,
  output logic       step_pulse,
  output logic [3:0] coils,
  output logic       busy,
  output logic [1:0] mode,
  output logic       done
);

  motion_state_t       r_state, w_next;
  logic                r_quarter_prev, w_fall;
  logic [PERIOD_W-1:0] r_period, w_sel_period;
  logic                r_dir, r_full;
  logic [6:0]          r_target, r_steps;
  logic [2:0]          r_phase, w_inc, w_phase_nxt;
  logic [3:0]          r_coils;
  logic                r_busy, r_done;
  logic [1:0]          r_mode;
  logic                w_pulse, w_run, w_q_last, w_dir_eff, w_full_eff;

  assign w_fall   = r_quarter_prev & ~quarter_n;
  assign w_q_last = (r_state == QUARTER) && w_pulse && (r_steps == r_target - 7'd1);
  // drop run on the exit cycle so the counter is already clear when IDLE begins
  assign w_run    = ((r_state == CONT) && cont_en) || ((r_state == QUARTER) && !w_q_last);

  always_comb begin
    w_sel_period = PERIOD0;
    case (speed_sel)
      2'd1:    w_sel_period = PERIOD1;
      2'd2:    w_sel_period = PERIOD2;
      2'd3:    w_sel_period = PERIOD3;
      default: w_sel_period = PERIOD0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (cont_en)     w_next = CONT;
        else if (w_fall) w_next = QUARTER;
      end
      CONT:    if (!cont_en) w_next = IDLE;
      QUARTER: if (w_q_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // quarter turns use the settings captured at acceptance; continuous run follows live inputs
  assign w_dir_eff   = (r_state == QUARTER) ? r_dir  : dir;
  assign w_full_eff  = (r_state == QUARTER) ? r_full : step_size;
  assign w_inc       = w_full_eff ? 3'd2 : 3'd1;
  assign w_phase_nxt = w_dir_eff ? (r_phase + w_inc) : (r_phase - w_inc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_quarter_prev <= 1'b1;
      r_period       <= '0;
      r_dir          <= 1'b0;
      r_full         <= 1'b0;
      r_target       <= 7'd0;
      r_steps        <= 7'd0;
      r_phase        <= 3'd0;
      r_coils        <= 4'b0001;
      r_busy         <= 1'b0;
      r_mode         <= 2'd0;
      r_done         <= 1'b0;
    end else begin
      r_quarter_prev <= quarter_n;
      r_busy         <= (w_next != IDLE);
      r_mode         <= w_next;
      r_done         <= w_q_last;
      if (r_state == IDLE && w_next != IDLE) begin
        r_period <= w_sel_period;
        r_dir    <= dir;
        r_full   <= step_size;
        r_target <= step_size ? QUARTER_STEPS_FULL : QUARTER_STEPS_HALF;
        r_steps  <= 7'd0;
      end else if (r_state == CONT && w_pulse) begin
        r_period <= w_sel_period;
      end
      if (r_state == QUARTER && w_pulse)
        r_steps <= r_steps + 7'd1;
      if (w_pulse) begin
        r_phase <= w_phase_nxt;
        r_coils <= coil_pattern(w_phase_nxt);
      end
    end
  end

  step_rate_gen #(
    .PERIOD_W (PERIOD_W)
  ) u_rate_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (w_run),
    .period     (r_period),
    .step_pulse (w_pulse)
  );

  assign step_pulse = w_pulse;
  assign coils      = r_coils;
  assign busy       = r_busy;
  assign mode       = r_mode;
  assign done       = r_done;

endmodule
